// File: rtl/spi_frame_ctrl_if.sv
// spi_frame_ctrl_if: bundles the raw SPI pins and the register-bank write/error
// outputs of spi_frame_ctrl.
//   master : drives sclk/ncs/copi, observes write strobe, error pulse, frame count
//   slave  : the frame controller side
interface spi_frame_ctrl_if;
    logic       sclk;
    logic       ncs;
    logic       copi;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       err_valid;
    logic [1:0] err_code;
    logic [7:0] frame_cnt;

    modport master (
        output sclk, ncs, copi,
        input  wr_valid, wr_addr, wr_data, err_valid, err_code, frame_cnt
    );

    modport slave (
        input  sclk, ncs, copi,
        output wr_valid, wr_addr, wr_data, err_valid, err_code, frame_cnt
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: synchronizes raw SPI pins into clk, deserializes 16-bit write
// frames (R/W, addr[6:0], data[7:0], MSB first) and, when nCS deasserts, issues one
// write strobe per valid frame or an error pulse for a malformed one.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport - sclk/ncs/copi in; wr_valid/wr_addr/wr_data,
//           err_valid/err_code, frame_cnt out
module spi_frame_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_frame_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StShift, StCheck, StCommit} state_e;

    localparam logic [4:0] CntFull = 5'd16;
    localparam logic [4:0] CntOvf  = 5'd17;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
    logic [SYNC_STAGES:0]   flush_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, ncs_s, copi_s, sclk_rise, flush_done;

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        err_valid_q, err_valid_d;
    logic [1:0]  err_code_q, err_code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            copi_sync_q <= '0;
            flush_q     <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], bus.copi};
            flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s      = ncs_sync_q[SYNC_STAGES-1];
    assign copi_s     = copi_sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    // The synchronizer's reset value of ncs=1 is not a real observation of the pin;
    // arming waits until the chain holds sampled data so a frame already in flight
    // at reset release is not picked up mid-way.
    assign flush_done = flush_q[SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            frame_cnt_q <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        frame_cnt_d = frame_cnt_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;

        unique case (state_q)
            StIdle: begin
                if (flush_done && ncs_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !ncs_s) begin
                    state_d = StShift;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_s};
                    if (cnt_q != CntOvf) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                if (ncs_s) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // Error pulse is registered so it lines up with wr_valid, which is
                // only visible once COMMIT has been entered.
                state_d = StIdle;
                if (cnt_q < CntFull) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 2'b01;
                end else if (cnt_q == CntOvf) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 2'b10;
                end else if (!shift_q[15]) begin
                    // Read frame: nothing to do, dropped silently.
                end else if (32'(shift_q[14:8]) >= NUM_REGS) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 2'b11;
                end else begin
                    state_d     = StCommit;
                    addr_d      = shift_q[14:8];
                    data_d      = shift_q[7:0];
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.wr_valid  = (state_q == StCommit);
    assign bus.wr_addr   = addr_q;
    assign bus.wr_data   = data_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed bench for spi_frame_ctrl with SCLK = clk/8.
// A negedge monitor logs every wr_valid / err_valid pulse; the main sequence
// compares logged pulses and outputs against hand-computed values.
module tb_spi_frame_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_frame_ctrl_if bus_if ();

    spi_frame_ctrl #(
        .SYNC_STAGES (2),
        .NUM_REGS    (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;

    int         wr_seen   = 0;
    int         err_seen  = 0;
    int         both_seen = 0;
    logic [1:0] last_code = 2'b00;
    logic [6:0] log_addr[$];
    logic [7:0] log_data[$];
    logic [7:0] log_cnt[$];

    always @(negedge clk) begin
        if (bus_if.wr_valid === 1'b1) begin
            wr_seen++;
            log_addr.push_back(bus_if.wr_addr);
            log_data.push_back(bus_if.wr_data);
            log_cnt.push_back(bus_if.frame_cnt);
        end
        if (bus_if.err_valid === 1'b1) begin
            err_seen++;
            last_code = bus_if.err_code;
        end
        if (bus_if.wr_valid === 1'b1 && bus_if.err_valid === 1'b1) begin
            both_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] frame, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus_if.copi = frame[i];
            tick(4);
            bus_if.sclk = 1'b1;
            tick(4);
            bus_if.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] frame, input int nbits, input int gap);
        bus_if.ncs = 1'b0;
        tick(4);
        shift_bits(frame, nbits);
        tick(4);
        bus_if.ncs = 1'b1;
        tick(gap);
    endtask

    int base;

    initial begin
        bus_if.sclk = 1'b0;
        bus_if.ncs  = 1'b1;
        bus_if.copi = 1'b0;
        tick(3);

        // Reset values
        check("rst_wr_valid",  32'(bus_if.wr_valid),  32'h0);
        check("rst_err_valid", 32'(bus_if.err_valid), 32'h0);
        check("rst_wr_addr",   32'(bus_if.wr_addr),   32'h0);
        check("rst_wr_data",   32'(bus_if.wr_data),   32'h0);
        check("rst_err_code",  32'(bus_if.err_code),  32'h0);
        check("rst_frame_cnt", 32'(bus_if.frame_cnt), 32'h0);
        rst_n = 1'b1;
        tick(10);

        // Valid write 0xF0 -> addr 4
        send_frame(32'h84F0, 16, 12);
        check("w1_count", 32'(wr_seen), 32'd1);
        check("w1_addr",  32'(log_addr[0]), 32'h04);
        check("w1_data",  32'(log_data[0]), 32'hF0);
        check("w1_cnt",   32'(log_cnt[0]),  32'd1);
        check("w1_noerr", 32'(err_seen), 32'd0);
        check("w1_hold_addr", 32'(bus_if.wr_addr), 32'h04);
        check("w1_hold_data", 32'(bus_if.wr_data), 32'hF0);

        // Short frame
        send_frame(32'h4278, 15, 12);
        check("short_err",  32'(err_seen), 32'd1);
        check("short_code", 32'(last_code), 32'h1);
        check("short_nowr", 32'(wr_seen), 32'd1);

        // Long frame
        send_frame(32'h109E1, 17, 12);
        check("long_err",  32'(err_seen), 32'd2);
        check("long_code", 32'(last_code), 32'h2);
        check("long_held", 32'(bus_if.err_code), 32'h2);
        check("long_nowr", 32'(wr_seen), 32'd1);

        // Address out of range
        send_frame(32'h85AA, 16, 12);
        check("badaddr_err",  32'(err_seen), 32'd3);
        check("badaddr_code", 32'(last_code), 32'h3);
        check("badaddr_nowr", 32'(wr_seen), 32'd1);

        // Read frame: silently dropped
        send_frame(32'h0455, 16, 12);
        check("read_nowr", 32'(wr_seen), 32'd1);
        check("read_noerr", 32'(err_seen), 32'd3);
        check("read_cnt", 32'(bus_if.frame_cnt), 32'd1);

        // Five back-to-back writes at minimum nCS high time
        base = wr_seen;
        send_frame(32'h8011, 16, 5);
        send_frame(32'h8122, 16, 5);
        send_frame(32'h8233, 16, 5);
        send_frame(32'h8344, 16, 5);
        send_frame(32'h8455, 16, 5);
        tick(10);
        check("b2b_count", 32'(wr_seen), 32'd6);
        check("b2b_a0", 32'(log_addr[base+0]), 32'h00);
        check("b2b_d0", 32'(log_data[base+0]), 32'h11);
        check("b2b_a1", 32'(log_addr[base+1]), 32'h01);
        check("b2b_d1", 32'(log_data[base+1]), 32'h22);
        check("b2b_a2", 32'(log_addr[base+2]), 32'h02);
        check("b2b_d2", 32'(log_data[base+2]), 32'h33);
        check("b2b_a3", 32'(log_addr[base+3]), 32'h03);
        check("b2b_d3", 32'(log_data[base+3]), 32'h44);
        check("b2b_a4", 32'(log_addr[base+4]), 32'h04);
        check("b2b_d4", 32'(log_data[base+4]), 32'h55);
        check("b2b_cnt", 32'(bus_if.frame_cnt), 32'd6);
        check("b2b_noerr", 32'(err_seen), 32'd3);

        // Reset in the middle of a frame
        bus_if.ncs = 1'b0;
        tick(4);
        shift_bits(32'h82, 8);
        rst_n = 1'b0;
        tick(2);
        check("midrst_cnt",  32'(bus_if.frame_cnt), 32'd0);
        check("midrst_addr", 32'(bus_if.wr_addr), 32'h0);
        check("midrst_code", 32'(bus_if.err_code), 32'h0);
        rst_n = 1'b1;
        tick(2);
        shift_bits(32'h22, 8);
        tick(4);
        bus_if.ncs = 1'b1;
        tick(12);
        check("midrst_nowr",  32'(wr_seen), 32'd6);
        check("midrst_noerr", 32'(err_seen), 32'd3);

        send_frame(32'h8133, 16, 12);
        check("postrst_count", 32'(wr_seen), 32'd7);
        check("postrst_addr",  32'(log_addr[6]), 32'h01);
        check("postrst_data",  32'(log_data[6]), 32'h33);
        check("postrst_cnt",   32'(bus_if.frame_cnt), 32'd1);

        // 255 more commits: the 256th since reset wraps frame_cnt to 0
        for (int i = 1; i <= 255; i++) begin
            send_frame({16'h0, 1'b1, 7'(i % 5), 8'(i)}, 16, 5);
        end
        tick(10);
        check("wrap_count",   32'(wr_seen), 32'd262);
        check("wrap_cnt255",  32'(log_cnt[260]), 32'd255);
        check("wrap_cnt0",    32'(log_cnt[261]), 32'd0);
        check("wrap_out",     32'(bus_if.frame_cnt), 32'd0);
        check("wrap_addr",    32'(log_addr[261]), 32'h00);
        check("wrap_data",    32'(log_data[261]), 32'hFF);
        check("never_both",   32'(both_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
